fmt_num_parser: RTL and testbench

//  Hardware counterpart to $display-style formatted output: consumes an ASCII

---
 rtl/fmt_parse_pkg.sv | 36 +++
 rtl/ascii_digit_decode.sv | 48 ++++
 rtl/fmt_num_parser.sv | 104 ++++++++++
 tb/tb_fmt_num_parser.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fmt_parse_pkg.sv
// Shared types and constants for the formatted-number parser.
// Radix codes mirror the %d/%h/%b selectors of the text producer.
package fmt_parse_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC  = 2'd0,
    RADIX_HEX  = 2'd1,
    RADIX_BIN  = 2'd2,
    RADIX_RSVD = 2'd3
  } radix_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  function automatic logic [4:0] radix_base(
    input radix_t r
  );
    logic [4:0] b;
    unique case (r)
      RADIX_DEC: b = 5'd10;
      RADIX_HEX: b = 5'd16;
      RADIX_BIN: b = 5'd2;
      default:   b = 5'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII classifier: delimiter detect plus
// digit value and validity for the selected radix.
module ascii_digit_decode
  import fmt_parse_pkg::*;
(
  input  logic [7:0] ch,
  input  radix_t     radix,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_delim
);

  logic dec_c;
  logic lo_c;
  logic up_c;
  logic bin_c;

  assign dec_c = (ch >= 8'h30) && (ch <= 8'h39);
  assign lo_c  = (ch >= 8'h61) && (ch <= 8'h66);
  assign up_c  = (ch >= 8'h41) && (ch <= 8'h46);
  assign bin_c = (ch == 8'h30) || (ch == 8'h31);

  assign is_delim = (ch == ASCII_SP)
                 || (ch == ASCII_COMMA)
                 || (ch == ASCII_LF)
                 || (ch == ASCII_CR);

  always_comb begin
    digit = 4'd0;
    unique case (1'b1)
      dec_c:   digit = 4'(ch - 8'h30);
      lo_c:    digit = 4'(ch - 8'h57);
      up_c:    digit = 4'(ch - 8'h37);
      default: digit = 4'd0;
    endcase
  end

  always_comb begin
    is_digit = 1'b0;
    unique case (radix)
      RADIX_DEC: is_digit = dec_c;
      RADIX_HEX: is_digit = dec_c | lo_c | up_c;
      RADIX_BIN: is_digit = bin_c;
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/fmt_num_parser.sv
// Parses delimited dec/hex/bin ASCII tokens into WIDTH-bit values
// and emits them on a valid/ready stream with ovf/err/eol flags.
module fmt_num_parser
  import fmt_parse_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       radix,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_ovf,
  output logic             out_err,
  output logic             out_eol
);

  state_t           state;
  radix_t           rdx;
  radix_t           rsel;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic             err;
  logic [3:0]       digit;
  logic             is_digit;
  logic             is_delim;
  logic             fire;
  logic [WIDTH+3:0] base;
  logic [WIDTH+3:0] mac;

  assign in_ready = !out_valid;
  assign fire     = in_valid && in_ready;

  // First char of a token decodes with the live radix input.
  assign rsel = (state == ST_IDLE) ? radix_t'(radix) : rdx;

  ascii_digit_decode u_dec (
    .ch       (in_char),
    .radix    (rsel),
    .digit    (digit),
    .is_digit (is_digit),
    .is_delim (is_delim)
  );

  assign base = (WIDTH+4)'(radix_base(rdx));
  assign mac  = ({4'b0, acc} * base)
              + (WIDTH+4)'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rdx       <= RADIX_DEC;
      acc       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fire && !is_delim) begin
            rdx   <= rsel;
            acc   <= is_digit ? WIDTH'(digit) : '0;
            err   <= !is_digit;
            ovf   <= 1'b0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (fire) begin
            if (is_delim) begin
              out_value <= acc;
              out_ovf   <= ovf;
              out_err   <= err;
              out_eol   <= (in_char == ASCII_LF);
              out_valid <= 1'b1;
              state     <= ST_EMIT;
            end else if (is_digit) begin
              acc <= mac[WIDTH-1:0];
              if (|mac[WIDTH+3:WIDTH]) ovf <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmt_num_parser.sv
// Scoreboard bench for fmt_num_parser: expected tokens are queued
// as text is driven and compared as the parser emits them.
module tb_fmt_num_parser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   radix = 2'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_char = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_value;
  logic         out_ovf;
  logic         out_err;
  logic         out_eol;

  typedef struct packed {
    logic [W-1:0] v;
    logic         ovf;
    logic         err;
    logic         eol;
  } tok_t;

  tok_t q[$];
  tok_t mt;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fmt_num_parser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .radix     (radix),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .out_eol   (out_eol)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_tok(
    input logic [W-1:0] v,
    input logic         o,
    input logic         e,
    input logic         l
  );
    tok_t t;
    t.v   = v;
    t.ovf = o;
    t.err = e;
    t.eol = l;
    q.push_back(t);
  endtask

  task automatic put(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_char  = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_token", 1, 0);
      end else begin
        mt = q.pop_front();
        check("value", 32'(out_value), 32'(mt.v));
        check("ovf", 32'(out_ovf), 32'(mt.ovf));
        check("err", 32'(out_err), 32'(mt.err));
        check("eol", 32'(out_eol), 32'(mt.eol));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle(2);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_value", 32'(out_value), 0);
    check("rst_ovf", 32'(out_ovf), 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_eol", 32'(out_eol), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    idle(2);

    radix = 2'd0;
    expect_tok(8'h2A, 0, 0, 1);
    send("42");
    put(8'h0A);
    check("latency", 32'(out_valid), 1);
    idle(2);

    radix = 2'd1;
    expect_tok(8'hAA, 0, 0, 0);
    send("aA ");
    radix = 2'd2;
    expect_tok(8'hAA, 0, 0, 0);
    send("10101010,");
    idle(2);

    radix = 2'd0;
    expect_tok(8'h00, 1, 0, 0);
    expect_tok(8'h07, 0, 0, 0);
    send("256 7 ");
    idle(2);

    expect_tok(8'h0C, 0, 1, 0);
    send("1x2 ");
    radix = 2'd3;
    expect_tok(8'h00, 0, 1, 0);
    send("5 ");
    idle(2);

    radix = 2'd0;
    send("  ,\r\n");
    idle(3);
    check("delim_only", 32'(out_valid), 0);
    expect_tok(8'h09, 0, 0, 1);
    send("9\n");
    idle(2);

    radix = 2'd1;
    put("1");
    radix = 2'd0;
    expect_tok(8'h1F, 0, 0, 0);
    send("f ");
    idle(2);

    @(posedge clk);
    #1 out_ready = 1'b0;
    expect_tok(8'h03, 0, 0, 0);
    expect_tok(8'h04, 0, 0, 0);
    fork
      send("3 4 ");
    join_none
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 32'(out_valid), 1);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_hold", 32'(out_value), 32'h03);
      check("bp_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait fork;
    idle(3);

    send("12");
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_value", 32'(out_value), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(" ");
    idle(4);
    check("mid_rst_no_out", 32'(out_valid), 0);
    expect_tok(8'h05, 0, 0, 1);
    send("5\n");

    idle(5);
    check("drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
